// File: rtl/mdu_param.sv
// HI/LO multiply/divide unit: multiply class completes in MULT_LAT cycles, restoring divide in WIDTH+1.
// Starts while busy are dropped; define MDU_PARAM_MACC_EN to enable MADD/MADDU/MSUB/MSUBU accumulate.
module mdu_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // opa_q doubles as the dividend/quotient shift register, opb_q as divisor magnitude
  logic [WIDTH-1:0] opa_q, opb_q, rem_q;
  logic             sgn_q, qneg_q, rneg_q, dz_q;
`ifdef MDU_PARAM_MACC_EN
  logic [1:0]       macc_q;
`endif

  logic [W2-1:0]    ext_a, ext_b, prod, mul_d;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_d, quo_d, quo_fix, rem_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;

  always_comb begin
    ext_a = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
    ext_b = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
    prod  = ext_a * ext_b;
    mul_d = prod;
`ifdef MDU_PARAM_MACC_EN
    case (macc_q)
      2'd1:    mul_d = {hi_q, lo_q} + prod;
      2'd2:    mul_d = {hi_q, lo_q} - prod;
      default: mul_d = prod;
    endcase
`endif
  end

  // One restoring step: a negative trial difference keeps the shifted remainder
  always_comb begin
    rem_sh  = {rem_q, opa_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb_q};
    rem_d   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_d   = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
    quo_fix = qneg_q ? -opa_q : opa_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
    a_neg   = ~op[0] & a[WIDTH-1];
    b_neg   = ~op[0] & b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MDU_PARAM_MACC_EN
      macc_q  <= 2'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              4'd0, 4'd1: begin
                state_q <= MUL;
                busy_q  <= 1'b1;
                cnt_q   <= CW'(MULT_LAT - 1);
                opa_q   <= a;
                opb_q   <= b;
                sgn_q   <= ~op[0];
`ifdef MDU_PARAM_MACC_EN
                macc_q  <= 2'd0;
`endif
              end
`ifdef MDU_PARAM_MACC_EN
              4'd6, 4'd7, 4'd8, 4'd9: begin
                state_q <= MUL;
                busy_q  <= 1'b1;
                cnt_q   <= CW'(MULT_LAT - 1);
                opa_q   <= a;
                opb_q   <= b;
                sgn_q   <= ~op[0];
                macc_q  <= op[3] ? 2'd2 : 2'd1;
              end
`endif
              4'd2, 4'd3: begin
                state_q <= DIV;
                busy_q  <= 1'b1;
                cnt_q   <= CW'(WIDTH);
                opa_q   <= a_mag;
                opb_q   <= b_mag;
                rem_q   <= '0;
                qneg_q  <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                dz_q    <= (b == '0);
              end
              4'd4:    hi_q <= a;
              4'd5:    lo_q <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            {hi_q, lo_q} <= mul_d;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DIV: begin
          if (cnt_q != '0) begin
            rem_q <= rem_d;
            opa_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // Final cycle applies signs; a zero divisor forces both results to zero
            hi_q    <= dz_q ? '0 : rem_fix;
            lo_q    <= dz_q ? '0 : quo_fix;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
